// File: rtl/rat_pkg.sv
// Shared types for the RAT MCU return-address stack: default address width,
// the address type and the error-tracking state encoding.
package rat_pkg;

    localparam int RAT_ADDR_W = 10;

    typedef logic [RAT_ADDR_W-1:0] rat_addr_t;

    typedef enum logic {
        RAS_OK,
        RAS_ERR
    } ras_state_t;

endpackage

// File: rtl/return_addr_stack_if.sv
// Strobe/data bundle between the control unit, the PC and the return-address
// stack. The master drives the CALL/RET strobes and the PC value; the slave
// (the stack) returns the popped address and its status flags.
interface return_addr_stack_if #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              PUSH;
    logic              POP;
    logic [ADDR_W-1:0] PC_IN;
    logic              CLR_ERR;
    logic [ADDR_W-1:0] RET_ADDR;
    logic              RET_VALID;
    logic              EMPTY;
    logic              FULL;
    logic [CNT_W-1:0]  DEPTH_CNT;
    logic              OVERFLOW;
    logic              UNDERFLOW;

    modport master (
        output PUSH, POP, PC_IN, CLR_ERR,
        input  RET_ADDR, RET_VALID, EMPTY, FULL, DEPTH_CNT, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  PUSH, POP, PC_IN, CLR_ERR,
        output RET_ADDR, RET_VALID, EMPTY, FULL, DEPTH_CNT, OVERFLOW, UNDERFLOW
    );

endinterface

// File: rtl/ras_mem.sv
// DEPTH x ADDR_W register file backing the return-address stack.
// One synchronous write port, one asynchronous read port. Contents are not
// reset; the stack's count decides which entries are meaningful.
module ras_mem #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [PTR_W-1:0]  i_waddr,
    input  logic [ADDR_W-1:0] i_wdata,
    input  logic [PTR_W-1:0]  i_raddr,
    output logic [ADDR_W-1:0] o_rdata
);

    logic [ADDR_W-1:0] r_mem [DEPTH];

    // Write the selected entry on the rising edge.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/return_addr_stack.sv
// Return-address stack for the RAT MCU fetch path. CALL pushes PC_IN+1,
// RET pops the top entry into a registered RET_ADDR with a one-cycle
// RET_VALID pulse. Sticky OVERFLOW/UNDERFLOW flags are tracked by a small
// OK/ERR state machine and cleared with CLR_ERR.
// Build option: define RAS_WRAP_EN to make a push while full overwrite the
// oldest entry (circular stack) instead of being dropped.
module return_addr_stack
    import rat_pkg::*;
#(
    parameter int ADDR_W = RAT_ADDR_W,
    parameter int DEPTH  = 16
) (
    input  logic                CLK,
    input  logic                RST,
    return_addr_stack_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0]  r_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_ret_addr;
    logic              r_ret_valid;
    logic              r_ovf;
    logic              r_udf;
    ras_state_t        r_state;

    logic [PTR_W-1:0]  w_ptr_nxt;
    logic [PTR_W-1:0]  w_rd_ptr;
    logic [PTR_W-1:0]  w_waddr;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [ADDR_W-1:0] w_ret_addr_nxt;
    logic [ADDR_W-1:0] w_push_val;
    logic [ADDR_W-1:0] w_top;
    logic              w_ret_valid_nxt;
    logic              w_we;
    logic              w_empty;
    logic              w_full;
    logic              w_ovf_evt;
    logic              w_udf_evt;
    logic              w_ovf_nxt;
    logic              w_udf_nxt;
    ras_state_t        w_state_nxt;

    assign w_empty    = (r_cnt == '0);
    assign w_full     = (r_cnt == CNT_W'(DEPTH));
    // Natural truncation gives the required wrap of the last address to 0.
    assign w_push_val = bus.PC_IN + ADDR_W'(1);
    assign w_rd_ptr   = r_ptr - PTR_W'(1);

    ras_mem #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .i_clk   (CLK),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_push_val),
        .i_raddr (w_rd_ptr),
        .o_rdata (w_top)
    );

    // Decode PUSH/POP against the current fill level into pointer, count,
    // storage-write and return-address updates plus error events.
    always_comb begin
        w_ptr_nxt       = r_ptr;
        w_cnt_nxt       = r_cnt;
        w_ret_addr_nxt  = r_ret_addr;
        w_ret_valid_nxt = 1'b0;
        w_we            = 1'b0;
        w_waddr         = r_ptr;
        w_ovf_evt       = 1'b0;
        w_udf_evt       = 1'b0;

        if (bus.PUSH && bus.POP && !w_empty) begin
            // Replace top: return the old top, overwrite it in place.
            w_we            = 1'b1;
            w_waddr         = w_rd_ptr;
            w_ret_addr_nxt  = w_top;
            w_ret_valid_nxt = 1'b1;
        end else if (bus.PUSH) begin
            // Also covers PUSH+POP on an empty stack, which acts as a push.
            if (!w_full) begin
                w_we      = 1'b1;
                w_ptr_nxt = r_ptr + PTR_W'(1);
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end else begin
                w_ovf_evt = 1'b1;
`ifdef RAS_WRAP_EN
                // When full the write slot holds the oldest entry.
                w_we      = 1'b1;
                w_ptr_nxt = r_ptr + PTR_W'(1);
`endif
            end
        end else if (bus.POP) begin
            w_ret_valid_nxt = 1'b1;
            if (!w_empty) begin
                w_ptr_nxt      = w_rd_ptr;
                w_cnt_nxt      = r_cnt - CNT_W'(1);
                w_ret_addr_nxt = w_top;
            end else begin
                w_ret_addr_nxt = '0;
                w_udf_evt      = 1'b1;
            end
        end
    end

    // Error tracking: a new event always wins over CLR_ERR.
    always_comb begin
        w_state_nxt = r_state;
        w_ovf_nxt   = r_ovf;
        w_udf_nxt   = r_udf;
        case (r_state)
            RAS_OK: begin
                if (w_ovf_evt || w_udf_evt) begin
                    w_state_nxt = RAS_ERR;
                    w_ovf_nxt   = w_ovf_evt;
                    w_udf_nxt   = w_udf_evt;
                end
            end
            RAS_ERR: begin
                if (w_ovf_evt || w_udf_evt) begin
                    w_ovf_nxt = r_ovf | w_ovf_evt;
                    w_udf_nxt = r_udf | w_udf_evt;
                end else if (bus.CLR_ERR) begin
                    w_state_nxt = RAS_OK;
                    w_ovf_nxt   = 1'b0;
                    w_udf_nxt   = 1'b0;
                end
            end
        endcase
    end

    // Register stack control, return path and error state; reset dominates.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_ret_addr  <= '0;
            r_ret_valid <= 1'b0;
            r_state     <= RAS_OK;
            r_ovf       <= 1'b0;
            r_udf       <= 1'b0;
        end else begin
            r_ptr       <= w_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ret_addr  <= w_ret_addr_nxt;
            r_ret_valid <= w_ret_valid_nxt;
            r_state     <= w_state_nxt;
            r_ovf       <= w_ovf_nxt;
            r_udf       <= w_udf_nxt;
        end
    end

    assign bus.RET_ADDR  = r_ret_addr;
    assign bus.RET_VALID = r_ret_valid;
    assign bus.EMPTY     = w_empty;
    assign bus.FULL      = w_full;
    assign bus.DEPTH_CNT = r_cnt;
    assign bus.OVERFLOW  = r_ovf;
    assign bus.UNDERFLOW = r_udf;

endmodule

// File: doc/return_addr_stack.md
Name: return_addr_stack

Overview:
- Hardware return-address stack for the RAT MCU fetch path; the partner of the program counter.
- On CALL it captures the current program counter value plus one.
- On RET it supplies the saved address back to the program counter's load input (DIN via the PC mux).
- Sits between the control unit (PUSH/POP strobes), the program counter output and the PC source mux.

Parameters:
- ADDR_W, 10, width of program address (matches 1024-word ProgROM).
- DEPTH, 16, number of return-address entries; must be a power of two, minimum 2.

Ports:
- CLK  input  1  system clock, all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- PUSH  input  1  CALL strobe; saves PC_IN+1.
- POP  input  1  RET strobe; retrieves the top entry.
- PC_IN  input  ADDR_W  current program counter value.
- CLR_ERR  input  1  clears the sticky error flags.
- RET_ADDR  output  ADDR_W  registered return address for the PC load path.
- RET_VALID  output  1  one-cycle pulse; RET_ADDR is valid.
- EMPTY  output  1  count == 0.
- FULL  output  1  count == DEPTH.
- DEPTH_CNT  output  $clog2(DEPTH)+1  current number of entries.
- OVERFLOW  output  1  sticky; a push was attempted while FULL.
- UNDERFLOW  output  1  sticky; a pop was attempted while EMPTY.

Behaviour:
- Reset (RST=1 at clock edge): count=0, top pointer=0, RET_ADDR=0, RET_VALID=0, OVERFLOW=0, UNDERFLOW=0, EMPTY=1, FULL=0. Storage contents are don't-care.
- Reset has priority over every other input. A reset mid-sequence discards all entries.
- Push value: (PC_IN + 1) mod 2^ADDR_W, so 0x3FF wraps to 0x000.
- PUSH only, not FULL: write entry at the top pointer, pointer+1, count+1. RET_VALID=0.
- POP only, not EMPTY:
  - pointer-1, count-1.
  - RET_ADDR <= entry[pointer-1], registered.
  - RET_VALID=1 on the cycle after the strobe edge, i.e. one cycle of latency.
- PUSH and POP together, not EMPTY (replace top):
  - RET_ADDR <= old top, RET_VALID=1.
  - Top entry overwritten with PC_IN+1.
  - Count and pointer unchanged.
- PUSH and POP together while EMPTY: treated as a push only; UNDERFLOW is not set.
- POP while EMPTY: RET_ADDR <= 0, RET_VALID=1, UNDERFLOW <= 1, count stays 0.
- PUSH while FULL: the push is dropped, OVERFLOW <= 1, contents unchanged (see Optional Feature).
- Error flags: OVERFLOW and UNDERFLOW hold until CLR_ERR or RST.
  - If CLR_ERR coincides with a new error event, the error event wins and the flag stays 1.
- Error FSM: states OK and ERR.
  - OK -> ERR on any overflow or underflow event.
  - ERR -> OK on CLR_ERR with no concurrent error event.
  - OVERFLOW and UNDERFLOW are registered flags inside ERR.
- Pointer arithmetic is modulo DEPTH.
- EMPTY, FULL and DEPTH_CNT are derived from the registered count, so they update the cycle after the strobe.
- RET_ADDR holds its last value when no pop occurs; RET_VALID is a single-cycle pulse only.

Optional Feature:
- Macro: RAS_WRAP_EN.
- Defined: PUSH while FULL overwrites the oldest entry (circular stack).
  - Pointer advances, count stays DEPTH.
  - OVERFLOW is still set, so software can detect the lost frame.
- Undefined: PUSH while FULL is dropped as described in Behaviour.

Decomposition:
- Package rat_pkg:
  - constant RAT_ADDR_W = 10.
  - typedef logic [RAT_ADDR_W-1:0] rat_addr_t.
  - typedef enum {RAS_OK, RAS_ERR} ras_state_t.
- Sub-module ras_mem: DEPTH x ADDR_W register file.
  - One synchronous write port.
  - One asynchronous read port, addressed by pointer-1.
  - Instantiated once. Control and pointer logic stay in return_addr_stack.

Test Plan:
- Reset then PUSH with PC_IN=0x010 -> DEPTH_CNT=1, EMPTY=0; POP -> next cycle RET_ADDR=0x011, RET_VALID=1, EMPTY=1.
- Push PC_IN=0x100, 0x200, 0x3FF, then 3 POPs -> RET_ADDR sequence 0x000, 0x201, 0x101. The 0x3FF case wraps to 0x000.
- 16 pushes of 0x000..0x00F, then a 17th push -> FULL=1, OVERFLOW=1.
  - Without RAS_WRAP_EN: first pop returns 0x010.
  - With RAS_WRAP_EN: 17th push of 0x020 makes the first pop return 0x021, and the 16th pop returns 0x002.
- POP on empty stack -> RET_ADDR=0x000, RET_VALID=1, UNDERFLOW=1. CLR_ERR one cycle later -> UNDERFLOW=0.
- Stack holds 0x051 (from PC_IN=0x050); simultaneous PUSH (PC_IN=0x080) and POP -> RET_ADDR=0x051, DEPTH_CNT unchanged at 1; next POP -> RET_ADDR=0x081.
- Push 3 entries, assert RST coincident with POP -> RET_VALID=0, DEPTH_CNT=0, EMPTY=1, flags 0.
